cpu_mc: RTL and testbench

//   Multi-cycle, width-parametrised successor of the single-cycle Hack CPU core.

---
 rtl/cpu_mc.sv | 131 +++++++++++++
 tb/tb_cpu_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// Multi-cycle Hack CPU: 2 cycles per A/C instruction, +1 per M read or write at zero-wait memory.
// Each req holds with stable addr/wdata until its ack; HALT on jump-to-self until reset.
module cpu_mc #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 15,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_data,
  output logic                  dmem_rd_req,
  output logic                  dmem_wr_req,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0]      dmem_wdata,
  input  logic [WIDTH-1:0]      dmem_rdata,
  input  logic                  dmem_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_MEM_RD = 3'd2;
  localparam logic [2:0] S_MEM_WR = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]            state;
  logic [15:0]           ir;
  logic [WIDTH-1:0]      a_reg;
  logic [WIDTH-1:0]      d_reg;
  logic [WIDTH-1:0]      wdata_r;

  logic                  is_c;
  logic                  a_bit;
  logic                  dest_a;
  logic                  dest_d;
  logic                  dest_m;
  logic [2:0]            jmp;
  logic [WIDTH-1:0]      y_op;
  logic [WIDTH-1:0]      x1, x2, y1, y2, fout;
  logic [WIDTH-1:0]      alu;
  logic [WIDTH-1:0]      res;
  logic                  zr, ng, take, self_jmp;
  logic                  commit, to_wr;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign is_c   = ir[15];
  assign a_bit  = ir[12];
  assign dest_a = ir[5];
  assign dest_d = ir[4];
  assign dest_m = ir[3];
  assign jmp    = ir[2:0];
  assign pc_inc = pc + 1'b1;

  always_comb begin
    y_op = (state == S_MEM_RD) ? dmem_rdata : a_reg;
    x1   = ir[11] ? '0 : d_reg;
    x2   = ir[10] ? ~x1 : x1;
    y1   = ir[9] ? '0 : y_op;
    y2   = ir[8] ? ~y1 : y1;
    fout = ir[7] ? (x2 + y2) : (x2 & y2);
    alu  = ir[6] ? ~fout : fout;
  end

  // In MEM_WR the result was computed earlier and lives in wdata_r.
  always_comb begin
    res      = (state == S_MEM_WR) ? wdata_r : alu;
    zr       = (res == '0);
    ng       = res[WIDTH-1];
    take     = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    self_jmp = (jmp == 3'b111) && (a_reg[ADDR_WIDTH-1:0] == pc);
    commit   = ((state == S_EXEC) && is_c && !a_bit && !dest_m) ||
               ((state == S_MEM_RD) && dmem_ack && !dest_m) ||
               ((state == S_MEM_WR) && dmem_ack);
    to_wr    = (((state == S_EXEC) && is_c && !a_bit) ||
                ((state == S_MEM_RD) && dmem_ack)) && dest_m;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      ir      <= '0;
      a_reg   <= '0;
      d_reg   <= '0;
      wdata_r <= '0;
      pc      <= ADDR_WIDTH'(RESET_PC);
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!is_c) begin
            a_reg <= {{(WIDTH-15){1'b0}}, ir[14:0]};
            pc    <= pc_inc;
            state <= S_FETCH;
          end else if (a_bit) begin
            state <= S_MEM_RD;
          end
        end
        default: ;
      endcase
      if (to_wr) begin
        wdata_r <= alu;
        state   <= S_MEM_WR;
      end
      // A, D and pc all update on one edge so the old A feeds both address and target.
      if (commit) begin
        if (dest_d) d_reg <= res;
        if (dest_a) a_reg <= res;
        pc    <= take ? a_reg[ADDR_WIDTH-1:0] : pc_inc;
        state <= self_jmp ? S_HALT : S_FETCH;
      end
    end
  end

  assign imem_req    = !reset && (state == S_FETCH);
  assign imem_addr   = pc;
  assign dmem_rd_req = !reset && (state == S_MEM_RD);
  assign dmem_wr_req = !reset && (state == S_MEM_WR);
  assign dmem_addr   = a_reg[ADDR_WIDTH-1:0];
  assign dmem_wdata  = wdata_r;
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc with a ROM/RAM responder that inserts programmable wait states.
module tb_cpu_mc;
  localparam int W  = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [15:0]   imem_data = '0;
  logic          dmem_rd_req;
  logic          dmem_wr_req;
  logic [AW-1:0] dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic [W-1:0]  dmem_rdata = '0;
  logic          dmem_ack = 1'b0;
  logic [AW-1:0] pc;
  logic          halted;

  cpu_mc #(.WIDTH(W), .ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_rd_req(dmem_rd_req), .dmem_wr_req(dmem_wr_req), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0]   rom  [0:63];
  logic [W-1:0]  dram [0:63];
  int            imem_wait = 0;
  int            dmem_wait = 0;
  bit            resp_en = 1'b1;
  int            proto_err = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [W-1:0]  last_wr_data = '0;
  logic [AW-1:0] last_rd_addr = '0;
  int            checks = 0;
  int            errors = 0;

  // Memory responder: acts at negedge, so acks are seen by the DUT at the next posedge.
  initial begin
    int            icnt, dcnt;
    bit            i_pend, d_pend, i_done, r_done, w_done;
    logic [AW-1:0] i_hold, d_hold;
    logic [W-1:0]  wd_hold;
    icnt = 0; dcnt = 0; i_pend = 0; d_pend = 0; i_done = 0; r_done = 0; w_done = 0;
    i_hold = '0; d_hold = '0; wd_hold = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        icnt = 0; dcnt = 0; i_pend = 0; d_pend = 0; i_done = 0; r_done = 0; w_done = 0;
      end else begin
        if (i_done && imem_req) proto_err++;
        if (imem_req) begin
          if (i_pend && imem_addr !== i_hold) proto_err++;
          i_hold = imem_addr;
          if (icnt >= imem_wait) begin
            imem_ack = 1'b1; imem_data = rom[imem_addr[5:0]];
            icnt = 0; i_pend = 0; i_done = 1;
          end else begin
            imem_ack = 1'b0; icnt++; i_pend = 1; i_done = 0;
          end
        end else begin
          imem_ack = 1'b0; icnt = 0; i_pend = 0; i_done = 0;
        end

        if ((r_done && dmem_rd_req) || (w_done && dmem_wr_req)) proto_err++;
        r_done = 0; w_done = 0;
        if (dmem_rd_req || dmem_wr_req) begin
          if (d_pend && (dmem_addr !== d_hold || (dmem_wr_req && dmem_wdata !== wd_hold)))
            proto_err++;
          d_hold = dmem_addr; wd_hold = dmem_wdata;
          if (dcnt >= dmem_wait) begin
            dmem_ack = 1'b1; dcnt = 0; d_pend = 0;
            if (dmem_rd_req) begin
              dmem_rdata = dram[dmem_addr[5:0]]; last_rd_addr = dmem_addr; r_done = 1;
            end else begin
              dram[dmem_addr[5:0]] = dmem_wdata;
              last_wr_addr = dmem_addr; last_wr_data = dmem_wdata; wr_cnt++; w_done = 1;
            end
          end else begin
            dmem_ack = 1'b0; dcnt++; d_pend = 1;
          end
        end else begin
          dmem_ack = 1'b0; dcnt = 0; d_pend = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      rom[i]  = 16'h0000;
      dram[i] = '0;
    end
    wr_cnt = 0;
  endtask

  initial begin
    int n;
    int req_seen;

    // Reset state and test 1: zero-wait store sequence.
    clear_mem();
    rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
    cycles(2);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_rd_req", dmem_rd_req, 0);
    check("rst_wr_req", dmem_wr_req, 0);
    check("rst_a", dut.a_reg, 0);
    check("rst_d", dut.d_reg, 0);
    reset = 1'b0;
    cycles(8);
    check("t1_pc_at_8", pc, 3);
    cycles(1);
    check("t1_pc_at_9", pc, 4);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_wr_addr", last_wr_addr, 3);
    check("t1_wr_data", last_wr_data, 2);
    check("t1_a", dut.a_reg, 3);
    check("t1_d", dut.d_reg, 2);

    // Test 2: same program with wait states.
    clear_mem();
    rom[0] = 16'h0002; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
    imem_wait = 3; dmem_wait = 2;
    do_reset();
    n = 0;
    while (pc !== 4 && n < 100) begin
      cycles(1);
      n++;
    end
    check("t2_cycles", n, 23);
    check("t2_ram3", dram[3], 2);
    check("t2_wr_cnt", wr_cnt, 1);
    check("t2_a", dut.a_reg, 3);
    check("t2_d", dut.d_reg, 2);
    check("t2_proto_err", proto_err, 0);
    imem_wait = 0; dmem_wait = 0;

    // Test 3: conditional jumps, ending on a self-jump.
    clear_mem();
    rom[0]  = 16'h000A; rom[1]  = 16'hEE90; rom[2]  = 16'hE304;
    rom[10] = 16'hEA90; rom[11] = 16'h0014; rom[12] = 16'hE301;
    rom[13] = 16'hE302; rom[20] = 16'hEA87;
    do_reset();
    cycles(6);
    check("t3_jlt_pc", pc, 10);
    check("t3_d_neg1", dut.d_reg, 16'hFFFF);
    cycles(6);
    check("t3_jgt_pc", pc, 13);
    cycles(2);
    check("t3_jeq_pc", pc, 20);
    cycles(2);
    check("t3_halted", halted, 1);
    check("t3_halt_pc", pc, 20);

    // Test 4: AM=M+1 with A=5, RAM[5]=7.
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hFDE8;
    dram[5] = 16'h0007;
    do_reset();
    cycles(5);
    check("t4_wr_req", dmem_wr_req, 1);
    check("t4_a_before", dut.a_reg, 5);
    check("t4_wr_addr_live", dmem_addr, 5);
    check("t4_wdata_live", dmem_wdata, 8);
    cycles(1);
    check("t4_ram5", dram[5], 8);
    check("t4_a_after", dut.a_reg, 8);
    check("t4_wr_addr", last_wr_addr, 5);
    check("t4_rd_addr", last_rd_addr, 5);
    check("t4_pc", pc, 2);

    // Test 5: halt on jump-to-self at pc=7, then reset.
    clear_mem();
    rom[6] = 16'h0007; rom[7] = 16'hEA87;
    do_reset();
    cycles(15);
    check("t5_not_halted_yet", halted, 0);
    cycles(1);
    check("t5_halted", halted, 1);
    check("t5_pc", pc, 7);
    req_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      if (imem_req || dmem_rd_req || dmem_wr_req) req_seen++;
    end
    check("t5_no_req", req_seen, 0);
    check("t5_pc_frozen", pc, 7);
    reset = 1'b1;
    cycles(1);
    check("t5_rst_pc", pc, 0);
    check("t5_rst_halted", halted, 0);
    reset = 1'b0;

    // Test 6: reset during MEM_RD with a simultaneous ack.
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hFC10;
    dmem_wait = 100;
    do_reset();
    n = 0;
    while (dmem_rd_req !== 1'b1 && n < 20) begin
      cycles(1);
      n++;
    end
    check("t6_reach_rd", dmem_rd_req, 1);
    resp_en = 1'b0;
    reset = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 16'h1234;
    #1;
    check("t6_rd_req_in_rst", dmem_rd_req, 0);
    check("t6_imem_req_in_rst", imem_req, 0);
    cycles(1);
    reset = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("t6_pc", pc, 0);
    check("t6_a", dut.a_reg, 0);
    check("t6_d", dut.d_reg, 0);
    check("t6_imem_req_after", imem_req, 1);
    check("t6_halted", halted, 0);
    dram[5] = 16'h0042;
    dmem_wait = 0;
    resp_en = 1'b1;
    cycles(5);
    check("t6_rerun_d", dut.d_reg, 16'h0042);
    check("t6_rerun_pc", pc, 2);
    check("proto_err_final", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
